// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Scoreboard fields are sized for the widest legal configuration (REG_AW <= 8, DEPTH <= 7).
package pipe_pkg;
  localparam int WD_W        = 8;
  localparam int RDY_W       = 3;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic             v;
    logic [WD_W-1:0]  wd;
    logic [RDY_W-1:0] rdy;
  } pipe_entry_t;

  function automatic int stage_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_hazard_match.sv
// Youngest-match priority encoder over the scoreboard for one source operand.
// PIPE_HAZARD_FWD_EN selects the forwarding hazard rule (s < rdy) over the wait-for-WB rule (s < DEPTH).
module pipe_hazard_match
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int SW     = 2
) (
  input  pipe_entry_t [DEPTH-1:0] ent_i,
  input  logic [REG_AW-1:0]       r_i,
  input  logic                    used_i,
  output logic                    hit_o,
  output logic [SW-1:0]           stage_o,
  output logic                    hazard_o
);

`ifdef PIPE_HAZARD_FWD_EN
  logic [RDY_W-1:0] rdy_m;
`else
  logic unused_rdy;
`endif

  always_comb begin
    hit_o    = 1'b0;
    stage_o  = '0;
    hazard_o = 1'b0;
`ifdef PIPE_HAZARD_FWD_EN
    rdy_m    = '0;
`else
    unused_rdy = 1'b0;
`endif
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
`ifndef PIPE_HAZARD_FWD_EN
      unused_rdy = unused_rdy ^ (^ent_i[i].rdy);
`endif
      if (used_i && (r_i != '0) && ent_i[i].v && (ent_i[i].wd == WD_W'(r_i))) begin
        hit_o   = 1'b1;
        stage_o = SW'(i + 1);
`ifdef PIPE_HAZARD_FWD_EN
        rdy_m   = ent_i[i].rdy;
`endif
      end
    end
`ifdef PIPE_HAZARD_FWD_EN
    hazard_o = hit_o && (int'(stage_o) < int'(rdy_m));
`else
    hazard_o = hit_o && (int'(stage_o) < DEPTH);
`endif
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard and forwarding controller sitting beside the ID stage.
// Define PIPE_HAZARD_FWD_EN to enable forwarding; otherwise consumers wait for WB and fwd_* stay 0.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [REG_AW-1:0]            id_rs,
  input  logic [REG_AW-1:0]            id_rt,
  input  logic                         id_rs_used,
  input  logic                         id_rt_used,
  input  logic                         id_wr,
  input  logic [REG_AW-1:0]            id_wd,
  input  logic                         id_load,
  output logic                         stall_id,
  output logic                         bubble_ex,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs_ex,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rt_ex,
  output logic [DEPTH-1:0]             pipe_valid
);

  localparam int SW = stage_w(DEPTH);

  pipe_entry_t [DEPTH-1:0] sb_q, sb_d;
  pipe_entry_t             issue;
  logic                    hit_rs, hit_rt, haz_rs, haz_rt;
  logic [SW-1:0]           stg_rs, stg_rt;

  pipe_hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SW(SW)) u_match_rs (
    .ent_i(sb_q), .r_i(id_rs), .used_i(id_rs_used),
    .hit_o(hit_rs), .stage_o(stg_rs), .hazard_o(haz_rs)
  );

  pipe_hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SW(SW)) u_match_rt (
    .ent_i(sb_q), .r_i(id_rt), .used_i(id_rt_used),
    .hit_o(hit_rt), .stage_o(stg_rt), .hazard_o(haz_rt)
  );

  // Flush overrides any pending stall; an empty or squashed ID slot issues a bubble.
  assign stall_id  = id_valid & ~flush & (haz_rs | haz_rt);
  assign bubble_ex = stall_id | flush | ~id_valid;

  always_comb begin
    issue = '0;
    if (!bubble_ex && id_wr && (id_wd != '0)) begin
      issue.v   = 1'b1;
      issue.wd  = WD_W'(id_wd);
      issue.rdy = id_load ? RDY_W'(LOAD_STAGE) : RDY_W'(1);
    end
    sb_d = sb_q;
    if (!hold) sb_d = {sb_q[DEPTH-2:0], issue};
  end

  always_ff @(posedge clk) begin
    if (reset) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) pipe_valid[i] = sb_q[i].v;
  end

`ifdef PIPE_HAZARD_FWD_EN
  logic [SW-1:0] fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;

  // A producer one stage past WB has already been written back, so read the register file.
  function automatic logic [SW-1:0] fwd_sel(input logic hit, input logic haz,
                                            input logic [SW-1:0] s);
    if (hit && !haz && (int'(s) + 1 <= DEPTH)) return SW'(int'(s) + 1);
    return SW'(FWD_REGFILE);
  endfunction

  always_comb begin
    fwd_rs_d = fwd_rs_q;
    fwd_rt_d = fwd_rt_q;
    if (!hold) begin
      fwd_rs_d = bubble_ex ? SW'(FWD_REGFILE) : fwd_sel(hit_rs, haz_rs, stg_rs);
      fwd_rt_d = bubble_ex ? SW'(FWD_REGFILE) : fwd_sel(hit_rt, haz_rt, stg_rt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_rs_q <= '0;
      fwd_rt_q <= '0;
    end else begin
      fwd_rs_q <= fwd_rs_d;
      fwd_rt_q <= fwd_rt_d;
    end
  end

  assign fwd_rs_ex = fwd_rs_q;
  assign fwd_rt_ex = fwd_rt_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{hit_rs, hit_rt, stg_rs, stg_rt};
  assign fwd_rs_ex  = SW'(FWD_REGFILE);
  assign fwd_rt_ex  = SW'(FWD_REGFILE);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic against a stage-list model.
module tb_pipe_hazard_ctrl;
  localparam int DEPTH      = 3;
  localparam int REG_AW     = 5;
  localparam int LOAD_STAGE = 2;
  localparam int SW         = $clog2(DEPTH + 1);
`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, hold, flush, id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_wd;
  logic              id_rs_used, id_rt_used, id_wr, id_load;
  logic              stall_id, bubble_ex;
  logic [SW-1:0]     fwd_rs_ex, fwd_rt_ex;
  logic [DEPTH-1:0]  pipe_valid;

  int checks = 0;
  int errors = 0;

  // Model: what each post-ID stage currently holds (stage 1 = EX).
  int mv   [1:DEPTH];
  int mwd  [1:DEPTH];
  int mrdy [1:DEPTH];
  int exp_fwd_rs, exp_fwd_rt;

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr(id_wr), .id_wd(id_wd), .id_load(id_load),
    .stall_id(stall_id), .bubble_ex(bubble_ex),
    .fwd_rs_ex(fwd_rs_ex), .fwd_rt_ex(fwd_rt_ex), .pipe_valid(pipe_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_match(input int r, input bit used, output int s, output bit haz);
    s   = 0;
    haz = 1'b0;
    if (used && r != 0)
      for (int i = DEPTH; i >= 1; i--)
        if (mv[i] != 0 && mwd[i] == r) s = i;
    if (s != 0) haz = FWD ? (s < mrdy[s]) : (s < DEPTH);
  endfunction

  function automatic int model_fwd(input bit bub, input int s, input bit haz);
    if (!FWD || bub || s == 0 || haz || s + 1 > DEPTH) return 0;
    return s + 1;
  endfunction

  task automatic model_clear();
    for (int i = 1; i <= DEPTH; i++) begin
      mv[i] = 0; mwd[i] = 0; mrdy[i] = 0;
    end
    exp_fwd_rs = 0;
    exp_fwd_rt = 0;
  endtask

  task automatic check_regs();
    logic [DEPTH-1:0] pv;
    for (int i = 1; i <= DEPTH; i++) pv[i-1] = (mv[i] != 0);
    chk("fwd_rs_ex", 32'(fwd_rs_ex), 32'(exp_fwd_rs));
    chk("fwd_rt_ex", 32'(fwd_rt_ex), 32'(exp_fwd_rt));
    chk("pipe_valid", 32'(pipe_valid), 32'(pv));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    check_regs();
  endtask

  // One ID-stage cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit v, input bit fl, input bit hd,
                      input int rs, input bit ru, input int rt, input bit tu,
                      input bit wr, input int wd, input bit ld, output bit obs_stall);
    int s_rs, s_rt;
    bit h_rs, h_rt, e_stall, e_bub;
    id_valid = v; flush = fl; hold = hd;
    id_rs = REG_AW'(rs); id_rs_used = ru;
    id_rt = REG_AW'(rt); id_rt_used = tu;
    id_wr = wr; id_wd = REG_AW'(wd); id_load = ld;
    #1;
    model_match(rs, ru, s_rs, h_rs);
    model_match(rt, tu, s_rt, h_rt);
    e_stall = v && !fl && (h_rs || h_rt);
    e_bub   = e_stall || fl || !v;
    obs_stall = stall_id;
    chk("stall_id", 32'(stall_id), 32'(e_stall));
    chk("bubble_ex", 32'(bubble_ex), 32'(e_bub));
    @(posedge clk);
    if (!hd) begin
      exp_fwd_rs = model_fwd(e_bub, s_rs, h_rs);
      exp_fwd_rt = model_fwd(e_bub, s_rt, h_rt);
      for (int i = DEPTH; i >= 2; i--) begin
        mv[i] = mv[i-1]; mwd[i] = mwd[i-1]; mrdy[i] = mrdy[i-1];
      end
      mv[1]   = (!e_bub && wr && wd != 0) ? 1 : 0;
      mwd[1]  = wd;
      mrdy[1] = ld ? LOAD_STAGE : 1;
    end
    #1;
    check_regs();
  endtask

  // Present an instruction until it leaves ID; returns the number of stall cycles seen.
  task automatic issue(input int rs, input bit ru, input int rt, input bit tu,
                       input bit wr, input int wd, input bit ld, output int nstall);
    bit st;
    bit done = 1'b0;
    nstall = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      step(1, 0, 0, rs, ru, rt, tu, wr, wd, ld, st);
      if (st) nstall++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_bound observed=stuck expected=released");
    end
  endtask

  initial begin
    bit st;
    int n;
    reset = 1'b1; hold = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_wr = 0; id_wd = 0; id_load = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_pipe_valid", 32'(pipe_valid), 0);

    // Empty scoreboard: no stall, bubble only when ID is empty.
    step(1, 0, 0, 8, 1, 9, 1, 0, 0, 0, st);
    step(0, 0, 0, 8, 1, 9, 1, 0, 0, 0, st);

    // ALU producer immediately followed by consumer.
    step(1, 0, 0, 0, 0, 0, 0, 1, 8, 0, st);
    issue(8, 1, 0, 0, 0, 0, 0, n);
    chk("alu_adj_stalls", 32'(n), FWD ? 0 : 2);
    chk("alu_adj_fwd", 32'(fwd_rs_ex), FWD ? 2 : 0);

    // ALU producer, one intervening instruction, consumer.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 8, 0, st);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    issue(8, 1, 0, 0, 0, 0, 0, n);
    chk("alu_gap_stalls", 32'(n), FWD ? 0 : 1);
    chk("alu_gap_fwd", 32'(fwd_rs_ex), FWD ? 3 : 0);

    // Load-use on rt.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, st);
    issue(0, 0, 9, 1, 0, 0, 0, n);
    chk("load_use_stalls", 32'(n), FWD ? 1 : 2);
    chk("load_use_fwd", 32'(fwd_rt_ex), FWD ? 3 : 0);

    // Two writers of the same register: youngest wins.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 10, 0, st);
    step(1, 0, 0, 0, 0, 0, 0, 1, 10, 0, st);
    issue(10, 1, 0, 0, 0, 0, 0, n);
    chk("youngest_stalls", 32'(n), FWD ? 0 : 2);
    chk("youngest_fwd", 32'(fwd_rs_ex), FWD ? 2 : 0);

    // Register 0 never matches.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, st);
    issue(0, 1, 0, 1, 0, 0, 0, n);
    chk("r0_stalls", 32'(n), 0);
    chk("r0_fwd", 32'(fwd_rs_ex), 0);

    // Hold for three cycles while a load-use is pending.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, st);
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 9, 1, 0, 0, 0, st);
    chk("hold_pipe_valid", 32'(pipe_valid), 1);
    issue(0, 0, 9, 1, 0, 0, 0, n);
    chk("hold_release_stalls", 32'(n), FWD ? 1 : 2);

    // Flush together with a hazard: flush wins.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, st);
    step(1, 1, 0, 0, 0, 9, 1, 1, 11, 0, st);
    chk("flush_stall", 32'(st), 0);
    chk("flush_bubble_pv", 32'(pipe_valid), 2);

    // Reset during a stall releases it.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, st);
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, st);
    chk("pre_reset_stall", 32'(st), 1);
    do_reset();
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, st);

    // Random traffic over a small register set to provoke frequent matches.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(7, 0) != 0, $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0,
           $urandom_range(3, 0), 1'($urandom), $urandom_range(3, 0), 1'($urandom),
           1'($urandom), $urandom_range(3, 0), 1'($urandom), st);
      if ($urandom_range(63, 0) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined CPU. It generalises the fixed EX/MEM/WB forwarding unit and the load-use hazard check into a single scoreboard over DEPTH post-decode stages, with configurable result latency and an external freeze. The block sits beside the ID stage. It takes decoded operand/destination info and drives the IF/ID hold, the ID/EX bubble and registered forwarding selects for the EX stage.

## Interface
- DEPTH, 3: number of tracked stages after ID (1=EX … DEPTH=WB); legal range 2–7
- REG_AW, 5: register index width
- LOAD_STAGE, 2: stage at whose end load data exists; 1 ≤ LOAD_STAGE < DEPTH
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  external freeze (multicycle unit/peripheral); scoreboard does not shift
- flush  in  1  squash the instruction in ID (branch/jump taken)
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source indices
- id_rs_used, id_rt_used  in  1  operand actually read
- id_wr  in  1  instruction writes a register
- id_wd  in  REG_AW  destination index (after RegDst selection)
- id_load  in  1  result ready at LOAD_STAGE rather than stage 1
- stall_id  out  1  hold PC and IF/ID (combinational)
- bubble_ex  out  1  zero ID/EX control this edge (combinational)
- fwd_rs_ex, fwd_rt_ex  out  $clog2(DEPTH+1)  registered; 0 = register file, k = stage-k result
- pipe_valid  out  DEPTH  per-stage valid+write flag, bit k-1 = stage k

## Operation
- Scoreboard entry per stage: {v, wd, rdy}; rdy = 1 for ALU ops, LOAD_STAGE for loads. Entries with wd = 0 are stored with v = 0, so register 0 never matches.
- Match(s, r): entry s has v = 1, wd == r, r != 0 and the operand is used. The youngest match (smallest s) wins.
- Hazard: a youngest match at s with s < rdy. The consumer would reach EX before the data exists.
- stall_id = id_valid & !flush & hazard(rs|rt). bubble_ex = stall_id | flush | !id_valid.
- Shift when !hold: stage 1 ← issued entry (bubble_ex ? invalid : {id_wr, id_wd, rdy}); stage k ← stage k-1. Stage DEPTH retires.
- Forward select, captured on the same edge: youngest match s without hazard gives fwd = s+1 if s+1 ≤ DEPTH, else 0. No match, or bubble_ex, gives fwd = 0.
- A retiring WB write is read through the register file, which is write-first.
- hold = 1: stage entries and fwd outputs keep their values. stall_id/bubble_ex are still computed but not consumed.
- flush and stall in the same cycle: flush wins, and stall_id = 0.

## Timing
- Reset (synchronous) clears every entry, pipe_valid = 0 and fwd_* = 0. With an empty scoreboard, stall_id = 0 and bubble_ex = !id_valid.
- stall_id/bubble_ex are combinational from ID inputs and current state, with zero latency.
- fwd_* are one-cycle registered and aligned to the instruction entering EX on the same edge.
- Load-use stall length is LOAD_STAGE − s cycles per hazard (1 cycle at defaults).
- Reset asserted mid-stall drops the stall on the next edge.

## Configuration
- PIPE_HAZARD_FWD_EN defined: forwarding as above.
- PIPE_HAZARD_FWD_EN undefined:
  - fwd_* are tied to 0.
  - Hazard becomes any match at s < DEPTH; the consumer waits until the producer reaches WB and reads it through the write-first register file.
  - rdy is ignored.

## Structure
- Shared package pipe_pkg: the scoreboard entry typedef (v, wd, rdy), the stage index width function and FWD_REGFILE = 0.
- One sub-module, pipe_hazard_match: combinational youngest-match priority encoder over DEPTH entries for one operand. Returns the hit, the stage index and the hazard flag. It is instantiated twice (rs, rt).

## Test plan
DEPTH=3, LOAD_STAGE=2 unless stated.
- Reset → pipe_valid=000, fwd_rs_ex=fwd_rt_ex=0, stall_id=0 with id_valid=1 and no writers.
- ALU writing $8, then a consumer with rs=8 next cycle → stall_id=0; fwd_rs_ex=2 after the edge. With one intervening instruction → fwd_rs_ex=3.
- Load to $9, then a consumer with rt=9 → stall_id=1 for exactly 1 cycle and pipe_valid shows the bubble; then fwd_rt_ex=3.
- Two consecutive ALU writes to $10, then a consumer with rs=10 → fwd_rs_ex=2 (youngest wins).
- A write to $0, then a reader of $0 → no stall, fwd=0.
- hold=1 for 3 cycles during a load-use → entries and fwd frozen, and the stall resolves only after hold drops.
- flush=1 together with a hazard → stall_id=0 and the bubble is inserted.
- Compiled without PIPE_HAZARD_FWD_EN, ALU writing $8 then a consumer of $8 → 2 stall cycles, then fwd_rs_ex=0.
